// File: rtl/tdm_pkg.sv
// Shared types and constants for the four-slot TDM receive path.
package tdm_pkg;

  typedef enum logic {HUNT, LOCKED} tdm_state_t;

  localparam int NUM_SLOTS = 4;
  localparam int SLOT_W    = 2;

endpackage

// File: rtl/tdm_demux4.sv
// Four-slot TDM demultiplexer: locks onto frame_sync, collects slots 0..2 in
// shadow registers and publishes all four channels together on the slot-3 sample.
//
// state  | meaning
// HUNT   | no alignment; unsynced samples are dropped until a frame_sync sample
// LOCKED | aligned; slot counts the next expected slot within the frame
module tdm_demux4
  import tdm_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  input  logic             frame_sync,
  output logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] c,
  output logic [WIDTH-1:0] d,
  output logic             frame_valid,
  output logic             locked,
  output logic             sync_err
);

  localparam logic [SLOT_W-1:0] FIRST_SLOT = '0;
  localparam logic [SLOT_W-1:0] LAST_SLOT  = SLOT_W'(NUM_SLOTS - 1);

  tdm_state_t        state, state_nx;
  logic [SLOT_W-1:0] slot, slot_nx;
  logic [WIDTH-1:0]  s0, s1, s2;
  logic [WIDTH-1:0]  s0_nx, s1_nx, s2_nx;
  logic [WIDTH-1:0]  a_nx, b_nx, c_nx, d_nx;
  logic              frame_valid_nx, sync_err_nx;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= HUNT;
      slot        <= '0;
      s0          <= '0;
      s1          <= '0;
      s2          <= '0;
      a           <= '0;
      b           <= '0;
      c           <= '0;
      d           <= '0;
      frame_valid <= 1'b0;
      sync_err    <= 1'b0;
    end else begin
      state       <= state_nx;
      slot        <= slot_nx;
      s0          <= s0_nx;
      s1          <= s1_nx;
      s2          <= s2_nx;
      a           <= a_nx;
      b           <= b_nx;
      c           <= c_nx;
      d           <= d_nx;
      frame_valid <= frame_valid_nx;
      sync_err    <= sync_err_nx;
    end
  end

  always_comb begin
    state_nx       = state;
    slot_nx        = slot;
    s0_nx          = s0;
    s1_nx          = s1;
    s2_nx          = s2;
    a_nx           = a;
    b_nx           = b;
    c_nx           = c;
    d_nx           = d;
    frame_valid_nx = 1'b0;
    sync_err_nx    = 1'b0;

    if (din_valid) begin
      unique case (state)
        HUNT: begin
          if (frame_sync) begin
            s0_nx    = din;
            slot_nx  = SLOT_W'(1);
            state_nx = LOCKED;
          end
        end

        LOCKED: begin
          if (slot == FIRST_SLOT) begin
            if (frame_sync) begin
              s0_nx   = din;
              slot_nx = SLOT_W'(1);
            end else begin
              sync_err_nx = 1'b1;
              state_nx    = HUNT;
            end
          end else if (frame_sync) begin
            // Early sync: drop the partial frame and restart on this sample.
            sync_err_nx = 1'b1;
            s0_nx       = din;
            slot_nx     = SLOT_W'(1);
          end else if (slot == LAST_SLOT) begin
            a_nx           = s0;
            b_nx           = s1;
            c_nx           = s2;
            d_nx           = din;
            frame_valid_nx = 1'b1;
            slot_nx        = FIRST_SLOT;
          end else begin
            if (slot == SLOT_W'(1)) s1_nx = din;
            else                    s2_nx = din;
            slot_nx = slot + SLOT_W'(1);
          end
        end

        default: begin
          state_nx = HUNT;
          slot_nx  = FIRST_SLOT;
        end
      endcase
    end
  end

  always_comb begin
    locked = (state == LOCKED);
  end

endmodule

// File: tb/tb_tdm_demux4.sv
// Directed self-checking bench for tdm_demux4 at WIDTH=8.
module tb_tdm_demux4;
  import tdm_pkg::*;

  localparam int WIDTH = 8;

  logic             clk;
  logic             rst_n;
  logic [WIDTH-1:0] din;
  logic             din_valid;
  logic             frame_sync;
  logic [WIDTH-1:0] a, b, c, d;
  logic             frame_valid;
  logic             locked;
  logic             sync_err;

  int n_checks;
  int n_fail;

  tdm_demux4 #(.WIDTH(WIDTH)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .din         (din),
    .din_valid   (din_valid),
    .frame_sync  (frame_sync),
    .a           (a),
    .b           (b),
    .c           (c),
    .d           (d),
    .frame_valid (frame_valid),
    .locked      (locked),
    .sync_err    (sync_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One accepted sample; returns 1 time unit after the capturing edge.
  task automatic send(input logic [WIDTH-1:0] v, input logic sync);
    @(negedge clk);
    din        = v;
    din_valid  = 1'b1;
    frame_sync = sync;
    @(posedge clk);
    #1;
    din_valid  = 1'b0;
    frame_sync = 1'b0;
  endtask

  task automatic idle(input logic sync);
    @(negedge clk);
    din_valid  = 1'b0;
    frame_sync = sync;
    @(posedge clk);
    #1;
    frame_sync = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n     = 1'b0;
    din_valid = 1'b0;
    @(posedge clk);
    #1;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if ({a, b, c, d} !== 32'h0) begin
      n_fail++; $display("FAIL reset_outputs: got %h want %h", {a, b, c, d}, 32'h0);
    end
    n_checks++;
    if ({locked, frame_valid, sync_err} !== 3'b000) begin
      n_fail++; $display("FAIL reset_flags: got %b want 000", {locked, frame_valid, sync_err});
    end
  endtask

  task automatic test_lock();
    send(8'h11, 1'b1);
    n_checks++;
    if (locked !== 1'b1) begin
      n_fail++; $display("FAIL lock_after_sync: locked=%b want 1", locked);
    end
    send(8'h22, 1'b0);
    send(8'h33, 1'b0);
    n_checks++;
    if ({frame_valid, a, b, c, d} !== {1'b0, 32'h0}) begin
      n_fail++; $display("FAIL lock_partial_leak: got %b %h want 0 00000000", frame_valid, {a, b, c, d});
    end
    send(8'h44, 1'b0);
    n_checks++;
    if ({frame_valid, locked, sync_err, a, b, c, d} !== {3'b110, 32'h11223344}) begin
      n_fail++; $display("FAIL lock_frame: got fv=%b lk=%b err=%b %h want 1 1 0 11223344",
                         frame_valid, locked, sync_err, {a, b, c, d});
    end
    idle(1'b0);
    n_checks++;
    if (frame_valid !== 1'b0) begin
      n_fail++; $display("FAIL lock_pulse_width: frame_valid=%b want 0", frame_valid);
    end
  endtask

  task automatic test_idle_gaps();
    send(8'h11, 1'b1);
    send(8'h22, 1'b0);
    for (int i = 0; i < 2; i++) begin
      idle(1'b1);
      n_checks++;
      if ({frame_valid, sync_err, locked, a, b, c, d} !== {3'b001, 32'h11223344}) begin
        n_fail++; $display("FAIL gap_hold: got fv=%b err=%b lk=%b %h want 0 0 1 11223344",
                           frame_valid, sync_err, locked, {a, b, c, d});
      end
    end
    send(8'h33, 1'b0);
    n_checks++;
    if (frame_valid !== 1'b0) begin
      n_fail++; $display("FAIL gap_early_fv: frame_valid=%b want 0", frame_valid);
    end
    send(8'h44, 1'b0);
    n_checks++;
    if ({frame_valid, a, b, c, d} !== {1'b1, 32'h11223344}) begin
      n_fail++; $display("FAIL gap_frame: got %b %h want 1 11223344", frame_valid, {a, b, c, d});
    end
  endtask

  task automatic test_hunt_discard();
    do_reset();
    send(8'hAA, 1'b0);
    send(8'hBB, 1'b0);
    idle(1'b1);
    n_checks++;
    if ({locked, frame_valid, sync_err, a, b, c, d} !== {3'b000, 32'h0}) begin
      n_fail++; $display("FAIL hunt_discard: got lk=%b fv=%b err=%b %h want 0 0 0 00000000",
                         locked, frame_valid, sync_err, {a, b, c, d});
    end
    send(8'h01, 1'b1);
    send(8'h02, 1'b0);
    send(8'h03, 1'b0);
    send(8'h04, 1'b0);
    n_checks++;
    if ({frame_valid, locked, a, b, c, d} !== {2'b11, 32'h01020304}) begin
      n_fail++; $display("FAIL hunt_frame: got fv=%b lk=%b %h want 1 1 01020304",
                         frame_valid, locked, {a, b, c, d});
    end
  endtask

  task automatic test_early_sync();
    send(8'h55, 1'b1);
    send(8'h66, 1'b0);
    send(8'h77, 1'b1);
    n_checks++;
    if ({sync_err, frame_valid, locked, a, b, c, d} !== {3'b101, 32'h01020304}) begin
      n_fail++; $display("FAIL early_err: got err=%b fv=%b lk=%b %h want 1 0 1 01020304",
                         sync_err, frame_valid, locked, {a, b, c, d});
    end
    send(8'h88, 1'b0);
    n_checks++;
    if (sync_err !== 1'b0) begin
      n_fail++; $display("FAIL early_err_width: sync_err=%b want 0", sync_err);
    end
    send(8'h99, 1'b0);
    send(8'hAA, 1'b0);
    n_checks++;
    if ({frame_valid, sync_err, a, b, c, d} !== {2'b10, 32'h778899AA}) begin
      n_fail++; $display("FAIL early_frame: got fv=%b err=%b %h want 1 0 778899aa",
                         frame_valid, sync_err, {a, b, c, d});
    end
  endtask

  task automatic test_missing_sync();
    send(8'hF0, 1'b0);
    n_checks++;
    if ({sync_err, locked, frame_valid, a, b, c, d} !== {3'b100, 32'h778899AA}) begin
      n_fail++; $display("FAIL missing_err: got err=%b lk=%b fv=%b %h want 1 0 0 778899aa",
                         sync_err, locked, frame_valid, {a, b, c, d});
    end
    send(8'hF1, 1'b0);
    n_checks++;
    if ({sync_err, locked} !== 2'b00) begin
      n_fail++; $display("FAIL missing_hunt: got err=%b lk=%b want 0 0", sync_err, locked);
    end
    send(8'h10, 1'b1);
    send(8'h20, 1'b0);
    send(8'h30, 1'b0);
    send(8'h40, 1'b0);
    n_checks++;
    if ({frame_valid, locked, a, b, c, d} !== {2'b11, 32'h10203040}) begin
      n_fail++; $display("FAIL missing_relock: got fv=%b lk=%b %h want 1 1 10203040",
                         frame_valid, locked, {a, b, c, d});
    end
  endtask

  task automatic test_reset_mid_frame();
    send(8'h5A, 1'b1);
    send(8'h5B, 1'b0);
    @(negedge clk);
    rst_n      = 1'b0;
    din        = 8'h5C;
    din_valid  = 1'b1;
    frame_sync = 1'b0;
    @(posedge clk);
    #1;
    n_checks++;
    if ({locked, frame_valid, sync_err, a, b, c, d} !== {3'b000, 32'h0}) begin
      n_fail++; $display("FAIL midreset: got lk=%b fv=%b err=%b %h want 0 0 0 00000000",
                         locked, frame_valid, sync_err, {a, b, c, d});
    end
    din_valid = 1'b0;
    rst_n     = 1'b1;
    send(8'hC1, 1'b1);
    send(8'hC2, 1'b0);
    send(8'hC3, 1'b0);
    send(8'hC4, 1'b0);
    n_checks++;
    if ({frame_valid, locked, a, b, c, d} !== {2'b11, 32'hC1C2C3C4}) begin
      n_fail++; $display("FAIL midreset_frame: got fv=%b lk=%b %h want 1 1 c1c2c3c4",
                         frame_valid, locked, {a, b, c, d});
    end
  endtask

  task automatic test_back_to_back();
    logic [WIDTH-1:0] v;
    for (int i = 0; i < 8; i++) begin
      v = 8'(8'hD0 + i);
      send(v, (i % 4) == 0);
      n_checks++;
      if (frame_valid !== ((i % 4) == 3)) begin
        n_fail++; $display("FAIL b2b_fv[%0d]: frame_valid=%b want %b", i, frame_valid, (i % 4) == 3);
      end
      n_checks++;
      if (sync_err !== 1'b0) begin
        n_fail++; $display("FAIL b2b_err[%0d]: sync_err=%b want 0", i, sync_err);
      end
    end
    n_checks++;
    if ({a, b, c, d} !== 32'hD4D5D6D7) begin
      n_fail++; $display("FAIL b2b_frame: got %h want d4d5d6d7", {a, b, c, d});
    end
  endtask

  initial begin
    n_checks   = 0;
    n_fail     = 0;
    rst_n      = 1'b0;
    din        = '0;
    din_valid  = 1'b0;
    frame_sync = 1'b0;
    test_reset();
    test_lock();
    test_idle_gaps();
    test_hunt_discard();
    test_early_sync();
    test_missing_sync();
    test_reset_mid_frame();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/tdm_demux4.md
Name: tdm_demux4

Overview:
- Receive-side counterpart of the team's 4:1 mux, used as a time-division multiplexer: one shared lane carries four channels in rotating slots 0..3, one slot per valid cycle.
- This block locks onto the frame marker and demultiplexes the lane back into four registered channel outputs.
- It publishes a complete frame atomically with a one-cycle strobe.
- It flags framing errors and re-acquires alignment after them.

Parameters:
- WIDTH, 1, bits per slot sample (1 matches the single-bit mux lane; 1..32 supported).

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- rst_n  input  1  synchronous, active-low reset.
- din  input  WIDTH  slot sample on the shared lane.
- din_valid  input  1  din carries a slot sample this cycle; low = idle, slot counter holds.
- frame_sync  input  1  qualified by din_valid; marks din as slot 0 of a frame.
- a  output  WIDTH  channel 0 (slot 0) of the last complete frame.
- b  output  WIDTH  channel 1 (slot 1).
- c  output  WIDTH  channel 2 (slot 2).
- d  output  WIDTH  channel 3 (slot 3).
- frame_valid  output  1  one-cycle pulse: a..d just updated.
- locked  output  1  high while in LOCKED state.
- sync_err  output  1  one-cycle pulse on any framing error.

Behaviour:
- Reset (rst_n low at a clock edge):
  - a, b, c, d = 0; frame_valid = 0; locked = 0; sync_err = 0.
  - slot = 0; shadow regs s0..s2 = 0; state = HUNT.
  - Reset mid-frame discards the partial frame; a..d are zeroed, not held.
- Sample acceptance: only cycles with din_valid = 1 are samples. frame_sync is ignored when din_valid = 0. Idle cycles hold all state.
- HUNT state:
  - Samples without frame_sync are discarded.
  - A sample with frame_sync: capture s0 = din, slot = 1, go to LOCKED; locked goes high next cycle.
- LOCKED state, slot 0 expected (slot == 0):
  - Sample with frame_sync: s0 = din, slot = 1.
  - Sample without frame_sync: sync_err pulse; sample discarded; go to HUNT; locked drops next cycle.
- LOCKED state, slot 1 or 2 expected:
  - Sample without frame_sync: s[slot] = din, slot += 1.
  - Sample with frame_sync (early sync): sync_err pulse; partial frame dropped; treat the sample as a new slot 0 (s0 = din, slot = 1); stay LOCKED.
- LOCKED state, slot 3 expected:
  - Sample without frame_sync: a = s0, b = s1, c = s2, d = din, all in the same edge. frame_valid = 1 for exactly one cycle. slot wraps to 0.
  - Sample with frame_sync: same early-sync handling as slots 1/2; no frame_valid.
- Latency: the slot-3 sample accepted at edge N makes a..d and frame_valid visible after edge N; frame_valid is high in the cycle after N.
- Outputs a..d change only on frame completion or reset. Partial frames never leak to the outputs.
- slot is 2 bits and wraps 3 -> 0 naturally.
- sync_err and frame_valid are never high in the same cycle.
- Back-to-back frames (no idle cycles) give a frame_valid pulse every 4th cycle.

Decomposition:
- Package tdm_pkg:
  - typedef enum logic {HUNT, LOCKED} tdm_state_t;
  - localparam NUM_SLOTS = 4;
  - localparam SLOT_W = 2.
- No sub-module needed. Slot counter, FSM and shadow registers fit in one always_ff plus a next-state always_comb.

Test Plan:
- Reset then lock (WIDTH=8): after reset a..d=0, locked=0. Send 4 consecutive valid samples 8'h11(sync), 8'h22, 8'h33, 8'h44 -> one cycle after the 4th sample: a=11, b=22, c=33, d=44, frame_valid=1 for one cycle, locked=1.
- Idle gaps: same frame with din_valid=0 for 2 cycles between slots 1 and 2 -> identical outputs; frame_valid only after slot 3; a..d unchanged during the gaps.
- Hunt discard: before any sync, send 8'hAA, 8'hBB unsynced -> no outputs change, locked=0. Then a synced frame 01,02,03,04 -> a..d = 01..04.
- Early sync: while locked, send 8'h55(sync), 8'h66, then 8'h77 with sync -> sync_err pulse on the 3rd sample. Continue 88, 99, AA -> a=77, b=88, c=99, d=AA, frame_valid=1; previous a..d held until then.
- Missing sync: after a complete frame, send 8'hF0 without sync -> sync_err=1, locked=0 next cycle, outputs held. A later synced frame re-locks.
- Reset mid-frame: after slots 0..1 of a frame, assert rst_n=0 for one cycle -> a..d=0, locked=0, no frame_valid. A following synced frame decodes correctly.
